avr_dma_master: RTL
===================

// Module: avr_dma_master
//
// PURPOSE
// Bus-initiator copy engine for the AVR data space: drives the same data bus the
// SoC memory/IO responder serves (addr, ren, wen, wdata, 1-cycle registered read data).
// Copies LEN bytes from SRC to DST via RAM or IO-mapped addresses. Arbitrates with
// the CPU through a bus_req/bus_gnt handshake; the SoC mux owns the grant.
//
// PARAMETERS
// LENBITS   12   width of transfer length / remaining count (max 4095 bytes)
//
// PORTS
// clk          in   1        system clock, all logic on posedge
// reset        in   1        synchronous, active-low (0 = reset)
// start        in   1        1-cycle pulse: latch src/dst/len, begin transfer
// src          in   16       source byte address
// dst          in   16       destination byte address
// len          in   LENBITS  byte count
// fill         in   1        fill mode select (only with AVR_DMA_FILL_EN)
// fill_val     in   8        fill byte (only with AVR_DMA_FILL_EN)
// abort        in   1        stop transfer at next edge
// bus_req      out  1        request data bus
// bus_gnt      in   1        data bus granted this cycle
// data_addr    out  16       bus address
// data_ren     out  1        read strobe
// data_wen     out  1        write strobe
// data_write   out  8        write data
// data_read    in   8        read data, valid the cycle after ren/addr
// busy         out  1        transfer in progress
// done         out  1        1-cycle pulse on normal completion
// remaining    out  LENBITS  bytes still to write
//
// BEHAVIOUR
// - Reset (reset==0 at edge): state IDLE; all outputs 0; mid-transfer reset abandons
//   transfer immediately, no done pulse, no further bus strobes.
// - States: IDLE -> REQ -> RD -> CAP -> WR -> (RD | IDLE).
// - IDLE: start latches src/dst/len; len==0 -> done pulses next cycle, no bus_req,
//   stay IDLE. Else busy=1, bus_req=1, remaining=len, go REQ. start ignored when busy.
// - REQ: wait for bus_gnt=1, then RD. bus_req stays 1 from REQ until IDLE.
// - RD: addr=src_cur, ren=1 only if bus_gnt; if gnt low, hold in RD with strobes 0.
// - CAP: addr held, strobes 0; capture data_read into hold reg; go WR.
// - WR: addr=dst_cur, data_write=hold, wen=1 only if bus_gnt (else hold in WR).
//   On the write: src_cur+1, dst_cur+1, remaining-1; remaining hits 0 -> IDLE, done=1
//   same edge busy=0, bus_req=0; else RD. Copy costs 3 granted cycles/byte.
// - Addresses wrap modulo 2^16 (16'hFFFF + 1 = 16'h0000); no range check; IO space
//   (<16'h0060) treated like RAM.
// - Overlap: strictly ascending copy; dst in (src, src+len) replicates source bytes.
// - abort: any non-IDLE state -> IDLE next edge, strobes 0, bus_req 0, no done;
//   a write strobed in the same cycle as abort completes. abort with start: abort wins.
// - Strobes never asserted while bus_gnt=0; ren and wen never both 1.
//
// CONFIGURATION
// - AVR_DMA_FILL_EN defined: fill=1 at start latches fill_val; FSM skips RD/CAP and
//   writes fill_val to dst_cur each granted cycle (1 cycle/byte); src unused.
// - AVR_DMA_FILL_EN undefined: fill and fill_val ignored; every transfer is a copy.
//
// TESTING
// - Copy src=0x0100 dst=0x0200 len=4, gnt=1, RAM 11 22 33 44 -> 0x200..0x203 = 11 22
//   33 44, done 12 cycles after REQ exit, remaining 4->0.
// - len=0 start -> done pulse next cycle, bus_req/ren/wen never asserted.
// - gnt low 5 cycles during WR of byte 2 -> wen held 0, resumes, data unchanged.
// - src=0xFFFE len=3 -> reads 0xFFFE, 0xFFFF, 0x0000 in order.
// - abort in CAP of byte 1 of len=8 -> IDLE next edge, no done, 1 byte written.
// - FILL_EN: fill=1 fill_val=0xA5 dst=0x0300 len=6 -> 6 bytes A5, 6 wen cycles, no ren.

Source files
------------

// File: rtl/avr_dma_master.sv
// Bus-initiator byte copy engine for the AVR data space, arbitrating with the CPU via bus_req/bus_gnt.
// Optional fill mode (constant byte written to a range) is built when AVR_DMA_FILL_EN is defined.
module avr_dma_master #(
  parameter int unsigned LENBITS = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        src,
  input  logic [15:0]        dst,
  input  logic [LENBITS-1:0] len,
  input  logic               fill,
  input  logic [7:0]         fill_val,
  input  logic               abort,
  output logic               bus_req,
  input  logic               bus_gnt,
  output logic [15:0]        data_addr,
  output logic               data_ren,
  output logic               data_wen,
  output logic [7:0]         data_write,
  input  logic [7:0]         data_read,
  output logic               busy,
  output logic               done,
  output logic [LENBITS-1:0] remaining
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    CAP,
    WR
  } state_t;

  state_t             state, state_nxt;
  logic [15:0]        src_cur, dst_cur;
  logic [LENBITS-1:0] rem;
  logic [7:0]         hold;
  logic               done_r;
  logic               write_fire;
  logic               accept;
  logic               last_byte;

`ifdef AVR_DMA_FILL_EN
  logic               fill_mode;
  logic [7:0]         fill_byte;
`else
  logic               fill_mode;
  logic [7:0]         fill_byte;
  logic               unused_fill;
  assign unused_fill = ^{fill, fill_val};
  assign fill_mode   = 1'b0;
  assign fill_byte   = '0;
`endif

  assign accept    = (state == IDLE) && start && !abort;
  assign last_byte = (rem == LENBITS'(1));

  always_comb begin
    state_nxt  = state;
    data_addr  = '0;
    data_ren   = 1'b0;
    data_wen   = 1'b0;
    data_write = '0;
    write_fire = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (len != '0)) state_nxt = REQ;
      end
      REQ: begin
        if (abort)        state_nxt = IDLE;
        else if (bus_gnt) state_nxt = fill_mode ? WR : RD;
      end
      RD: begin
        data_addr = src_cur;
        data_ren  = bus_gnt;
        if (abort)        state_nxt = IDLE;
        else if (bus_gnt) state_nxt = CAP;
      end
      CAP: begin
        data_addr = src_cur;
        state_nxt = abort ? IDLE : WR;
      end
      WR: begin
        // a write strobed alongside abort still lands; only the follow-on is dropped
        data_addr  = dst_cur;
        data_write = fill_mode ? fill_byte : hold;
        data_wen   = bus_gnt;
        write_fire = bus_gnt;
        if (abort)        state_nxt = IDLE;
        else if (bus_gnt) state_nxt = last_byte ? IDLE : (fill_mode ? WR : RD);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      src_cur <= '0;
      dst_cur <= '0;
      rem     <= '0;
      hold    <= '0;
      done_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= 1'b0;
      if (accept) begin
        src_cur <= src;
        dst_cur <= dst;
        rem     <= len;
        if (len == '0) done_r <= 1'b1;
      end
      if (state == CAP) hold <= data_read;
      if (write_fire) begin
        src_cur <= src_cur + 16'd1;
        dst_cur <= dst_cur + 16'd1;
        rem     <= rem - LENBITS'(1);
        if (last_byte && !abort) done_r <= 1'b1;
      end
    end
  end

`ifdef AVR_DMA_FILL_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_mode <= 1'b0;
      fill_byte <= '0;
    end else if (accept) begin
      fill_mode <= fill;
      fill_byte <= fill_val;
    end
  end
`endif

  assign busy      = (state != IDLE);
  assign bus_req   = (state != IDLE);
  assign done      = done_r;
  assign remaining = rem;

endmodule
